hsv_core_mem_request: RTL and testbench
=======================================

Name: hsv_core_mem_request

Overview:
- Issue stage of the data-memory path. Sits between the memory-op decode/dispatch and the memory response stage.
- Per accepted op, checks alignment and builds AXI AR, or AW+W with byte strobes. Owns the pending-read and pending-write counters and forwards each op to the response stage through a single output register.
- Misaligned ops and fences generate no bus traffic. They are forwarded so the response stage can raise the exception or drain the fence.

Parameters:
- COUNTER_W, 4: width of the pending_reads/pending_writes counters; saturates at 2**COUNTER_W-1.

Ports:
- clk_core  in  1  core clock; all state on rising edge
- rst_core  in  1  reset, asynchronous, active-high
- flush  in  1  pipeline flush
- valid_i  in  1  input op valid
- request_stall  out  1  input op not accepted this cycle
- in_address  in  32  effective address
- in_write  in  1  1=store, 0=load
- in_size  in  2  0=byte, 1=half, 2=word (3 illegal, treated as word)
- in_wdata  in  32  store data, LSB-aligned
- in_fence  in  1  op is a fence
- in_is_memory  in  1  1=ordinary memory, 0=I/O
- dmem_ar_valid/ready/addr  out/in/out  1/1/32  AXI read address
- dmem_aw_valid/ready/addr  out/in/out  1/1/32  AXI write address
- dmem_w_valid/ready  out/in  1/1  AXI write data handshake
- dmem_w_data  out  32  write data
- dmem_w_strb  out  4  write strobes
- pending_reads_down  in  1  R beat consumed (from response stage)
- pending_writes_down  in  1  B beat consumed (from response stage)
- pending_reads  out  COUNTER_W  outstanding reads
- pending_writes  out  COUNTER_W  outstanding writes
- response_stall  in  1  response stage cannot take a new op
- valid_o  out  1  output register holds a valid op
- out_address/out_write/out_size/out_fence/out_is_memory  out  32/1/2/1/1  registered copy of op
- out_misaligned  out  1  registered misalignment flag

Behaviour:
- Reset values: all outputs 0. FSM in IDLE. Counters 0.
- Misaligned:
  - half with address[0]=1;
  - word with address[1:0]!=0;
  - byte never.
- Bus address: in_address with bits [1:0] cleared.
- Write data: byte replicated ×4, half replicated ×2, word as-is.
- Write strobes: byte 4'b0001<<a[1:0]; half 4'b0011<<a[1:0]; word 4'b1111.
- FSM states:
  - IDLE: no op being issued.
  - ISSUE: bus valids held. For stores, aw_done/w_done flags record completed channels independently.
  - DRAIN: flushed op still finishing handshakes.
- Accept condition: valid_i & ~request_stall.
  - request_stall=1 when valid_o&response_stall, when in ISSUE/DRAIN, or when the needed counter is saturated.
- Accept, no bus traffic (fence, or misaligned): op goes straight to output register next cycle (latency 1).
- Accept, bus op: FSM goes to ISSUE. Load asserts dmem_ar_valid; store asserts dmem_aw_valid and dmem_w_valid.
  - Valids are asserted the cycle after accept and held until ready. Address/data/strb stay stable while valid.
- Leaving ISSUE: when all required handshakes are done, the op loads the output register (latency 1 from last handshake) and the FSM returns to IDLE.
  - If response_stall blocks the output register, the FSM stays in ISSUE with valids deasserted.
- Counters:
  - pending_reads up on AR handshake; pending_writes up on AW handshake; downs from the response stage.
  - Simultaneous up and down leaves the value unchanged.
  - Never decrement below 0.
- Output register: holds while valid_o&response_stall; otherwise loads the next op or clears valid_o.
- flush:
  - Clears valid_o.
  - An IDLE op is dropped.
  - An ISSUE op moves to DRAIN: AXI valids are never withdrawn before ready. Handshakes complete and counters still increment, but the op is not forwarded. Return to IDLE.
  - Counters are not cleared by flush, because bus responses still arrive.
- rst_core mid-transaction: immediate return to reset values. The interconnect must be reset together.

Optional Feature:
- Macro: HSV_MEM_REQ_IO_ORDER_EN.
- Defined: an I/O op (in_is_memory=0, not a fence) is not accepted (request_stall=1) until pending_reads==0 and pending_writes==0. This gives strict ordering for device accesses.
- Undefined: I/O ops issue like memory ops; ordering is left to explicit fences.

Test Plan:
- Store byte, address 0x1003, data 0xAB: AW addr 0x1000, W data 0xABABABAB, strb 4'b1000; pending_writes 0→1; valid_o one cycle after both handshakes.
- Load half, address 0x2002, AR ready held low 3 cycles: dmem_ar_valid stays high with addr 0x2000; request_stall=1 throughout; pending_reads=1 after handshake.
- Load word, address 0x3001: no AR; valid_o next cycle with out_misaligned=1; counters unchanged.
- Store with AW ready in cycle 1 and W ready in cycle 3: aw_done retains state; op forwarded once, after cycle 3.
- flush during ISSUE of a load with AR stalled: valid_o=0; AR valid held until ready, then pending_reads increments; nothing forwarded.
- With HSV_MEM_REQ_IO_ORDER_EN, pending_writes=2 and an I/O load presented: stalls until two pending_writes_down pulses, then AR issues.

Source files
------------

// File: rtl/hsv_core_mem_request.sv
// hsv_core_mem_request
//   Issue stage of the data-memory path. Each accepted memory op is checked
//   for alignment and, if it needs the bus, turned into an AXI AR request
//   (load) or an AW + W pair with byte strobes (store). Misaligned ops and
//   fences skip the bus. Every op that is not flushed reaches the response
//   stage through one output register.
//
//   Optional feature macro: HSV_MEM_REQ_IO_ORDER_EN
//     defined   : an I/O op (in_is_memory=0, not a fence) waits until both
//                 pending counters are zero before it is accepted.
//     undefined : I/O ops issue exactly like memory ops.
//
// Ports
//   clk_core, rst_core       clock, async active-high reset
//   flush                    drop/abandon the current op and clear valid_o
//   valid_i / request_stall  op input handshake (accept = valid_i & ~request_stall)
//   in_*                     op fields (address, write, size, wdata, fence, is_memory)
//   dmem_ar_* / aw_* / w_*   AXI read address, write address, write data
//   pending_*_down           response-stage beat consumption pulses
//   pending_reads/writes     outstanding AXI transaction counters (saturating)
//   response_stall           response stage cannot take a new op
//   valid_o, out_*           registered op handed to the response stage
//   state_o                  FSM state, for observation only
//
// Handshake rule (all channels): a transfer happens on a rising clk_core edge
// where valid and ready are both 1. A valid, once raised, stays high with
// stable payload until that transfer, even across a flush.
module hsv_core_mem_request #(
  parameter int COUNTER_W = 4
) (
  input  logic                 clk_core,
  input  logic                 rst_core,
  input  logic                 flush,
  input  logic                 valid_i,
  output logic                 request_stall,
  input  logic [31:0]          in_address,
  input  logic                 in_write,
  input  logic [1:0]           in_size,
  input  logic [31:0]          in_wdata,
  input  logic                 in_fence,
  input  logic                 in_is_memory,
  output logic                 dmem_ar_valid,
  input  logic                 dmem_ar_ready,
  output logic [31:0]          dmem_ar_addr,
  output logic                 dmem_aw_valid,
  input  logic                 dmem_aw_ready,
  output logic [31:0]          dmem_aw_addr,
  output logic                 dmem_w_valid,
  input  logic                 dmem_w_ready,
  output logic [31:0]          dmem_w_data,
  output logic [3:0]           dmem_w_strb,
  input  logic                 pending_reads_down,
  input  logic                 pending_writes_down,
  output logic [COUNTER_W-1:0] pending_reads,
  output logic [COUNTER_W-1:0] pending_writes,
  input  logic                 response_stall,
  output logic                 valid_o,
  output logic [31:0]          out_address,
  output logic                 out_write,
  output logic [1:0]           out_size,
  output logic                 out_fence,
  output logic                 out_is_memory,
  output logic                 out_misaligned,
  output logic [1:0]           state_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [COUNTER_W-1:0] CNT_MAX = '1;

  logic [1:0]           state_q, state_d;
  logic [31:0]          op_addr_q, op_wdata_q;
  logic [3:0]           op_strb_q;
  logic                 op_write_q, op_is_mem_q;
  logic [1:0]           op_size_q;
  logic                 ar_done_q, aw_done_q, w_done_q;
  logic [COUNTER_W-1:0] pr_q, pw_q;
  logic                 valid_o_q, valid_o_d;
  logic [31:0]          out_addr_q, out_addr_d;
  logic                 out_write_q, out_write_d, out_fence_q, out_fence_d;
  logic                 out_is_mem_q, out_is_mem_d, out_mis_q, out_mis_d;
  logic [1:0]           out_size_q, out_size_d;

  // Input op decode. Size 3 is treated as a word.
  logic        misaligned_in, no_bus_in, cnt_full, io_block, accept, bus_accept;
  logic [31:0] wdata_in;
  logic [3:0]  strb_in;

  assign misaligned_in = ((in_size == 2'd1) & in_address[0]) |
                         (in_size[1] & (in_address[1:0] != 2'b00));
  assign no_bus_in     = in_fence | misaligned_in;
  assign cnt_full      = in_write ? (pw_q == CNT_MAX) : (pr_q == CNT_MAX);

`ifdef HSV_MEM_REQ_IO_ORDER_EN
  assign io_block = ~in_is_memory & ~in_fence & ((pr_q != '0) | (pw_q != '0));
`else
  assign io_block = 1'b0;
`endif

  always_comb begin
    wdata_in = in_wdata;
    strb_in  = 4'b1111;
    case (in_size)
      2'd0: begin
        wdata_in = {4{in_wdata[7:0]}};
        strb_in  = 4'b0001 << in_address[1:0];
      end
      2'd1: begin
        wdata_in = {2{in_wdata[15:0]}};
        strb_in  = 4'b0011 << in_address[1:0];
      end
      default: ;
    endcase
  end

  logic out_free;
  assign out_free      = ~(valid_o_q & response_stall);
  // A full counter only matters for ops that will actually touch the bus.
  assign request_stall = ~out_free | (state_q != ST_IDLE) |
                         (~no_bus_in & cnt_full) | io_block;
  // A flush in the accept cycle drops the incoming op.
  assign accept        = valid_i & ~request_stall & ~flush;
  assign bus_accept    = accept & ~no_bus_in;

  // Bus channel valids come straight from registered state, so they rise
  // the cycle after accept and drop the cycle after their own handshake.
  logic busy, ar_hs, aw_hs, w_hs, all_done, issue_fwd;
  assign busy          = (state_q != ST_IDLE);
  assign dmem_ar_valid = busy & ~op_write_q & ~ar_done_q;
  assign dmem_aw_valid = busy & op_write_q & ~aw_done_q;
  assign dmem_w_valid  = busy & op_write_q & ~w_done_q;
  assign ar_hs         = dmem_ar_valid & dmem_ar_ready;
  assign aw_hs         = dmem_aw_valid & dmem_aw_ready;
  assign w_hs          = dmem_w_valid & dmem_w_ready;
  assign all_done      = op_write_q ? ((aw_done_q | aw_hs) & (w_done_q | w_hs))
                                    : (ar_done_q | ar_hs);
  assign issue_fwd     = (state_q == ST_ISSUE) & ~flush & all_done & out_free;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus_accept) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (flush)         state_d = all_done ? ST_IDLE : ST_DRAIN;
        else if (issue_fwd) state_d = ST_IDLE;
      end
      ST_DRAIN: if (all_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_o_d    = 1'b0;
    out_addr_d   = out_addr_q;
    out_write_d  = out_write_q;
    out_size_d   = out_size_q;
    out_fence_d  = out_fence_q;
    out_is_mem_d = out_is_mem_q;
    out_mis_d    = out_mis_q;
    if (flush) begin
      valid_o_d = 1'b0;
    end else if (~out_free) begin
      valid_o_d = 1'b1;
    end else if (accept & no_bus_in) begin
      valid_o_d    = 1'b1;
      out_addr_d   = in_address;
      out_write_d  = in_write;
      out_size_d   = in_size;
      out_fence_d  = in_fence;
      out_is_mem_d = in_is_memory;
      out_mis_d    = misaligned_in;
    end else if (issue_fwd) begin
      valid_o_d    = 1'b1;
      out_addr_d   = op_addr_q;
      out_write_d  = op_write_q;
      out_size_d   = op_size_q;
      out_fence_d  = 1'b0;
      out_is_mem_d = op_is_mem_q;
      out_mis_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      state_q      <= ST_IDLE;
      op_addr_q    <= '0;
      op_wdata_q   <= '0;
      op_strb_q    <= '0;
      op_write_q   <= 1'b0;
      op_is_mem_q  <= 1'b0;
      op_size_q    <= '0;
      ar_done_q    <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      pr_q         <= '0;
      pw_q         <= '0;
      valid_o_q    <= 1'b0;
      out_addr_q   <= '0;
      out_write_q  <= 1'b0;
      out_size_q   <= '0;
      out_fence_q  <= 1'b0;
      out_is_mem_q <= 1'b0;
      out_mis_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus_accept) begin
        op_addr_q   <= in_address;
        op_wdata_q  <= wdata_in;
        op_strb_q   <= strb_in;
        op_write_q  <= in_write;
        op_is_mem_q <= in_is_memory;
        op_size_q   <= in_size;
        ar_done_q   <= 1'b0;
        aw_done_q   <= 1'b0;
        w_done_q    <= 1'b0;
      end else begin
        // Channels complete independently; remember each one.
        ar_done_q <= ar_done_q | ar_hs;
        aw_done_q <= aw_done_q | aw_hs;
        w_done_q  <= w_done_q | w_hs;
      end
      // Up and down together leave the count unchanged.
      if (ar_hs & ~pending_reads_down & (pr_q != CNT_MAX))      pr_q <= pr_q + 1'b1;
      else if (~ar_hs & pending_reads_down & (pr_q != '0))      pr_q <= pr_q - 1'b1;
      if (aw_hs & ~pending_writes_down & (pw_q != CNT_MAX))     pw_q <= pw_q + 1'b1;
      else if (~aw_hs & pending_writes_down & (pw_q != '0))     pw_q <= pw_q - 1'b1;
      valid_o_q    <= valid_o_d;
      out_addr_q   <= out_addr_d;
      out_write_q  <= out_write_d;
      out_size_q   <= out_size_d;
      out_fence_q  <= out_fence_d;
      out_is_mem_q <= out_is_mem_d;
      out_mis_q    <= out_mis_d;
    end
  end

  assign dmem_ar_addr   = {op_addr_q[31:2], 2'b00};
  assign dmem_aw_addr   = {op_addr_q[31:2], 2'b00};
  assign dmem_w_data    = op_wdata_q;
  assign dmem_w_strb    = op_strb_q;
  assign pending_reads  = pr_q;
  assign pending_writes = pw_q;
  assign valid_o        = valid_o_q;
  assign out_address    = out_addr_q;
  assign out_write      = out_write_q;
  assign out_size       = out_size_q;
  assign out_fence      = out_fence_q;
  assign out_is_memory  = out_is_mem_q;
  assign out_misaligned = out_mis_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_hsv_core_mem_request.sv
module tb_hsv_core_mem_request;
  localparam int COUNTER_W = 4;

  logic        clk_core = 1'b0;
  logic        rst_core = 1'b1;
  logic        flush = 1'b0, valid_i = 1'b0, request_stall;
  logic [31:0] in_address = '0, in_wdata = '0;
  logic        in_write = 1'b0, in_fence = 1'b0, in_is_memory = 1'b1;
  logic [1:0]  in_size = '0;
  logic        dmem_ar_valid, dmem_ar_ready = 1'b0;
  logic [31:0] dmem_ar_addr;
  logic        dmem_aw_valid, dmem_aw_ready = 1'b0;
  logic [31:0] dmem_aw_addr;
  logic        dmem_w_valid, dmem_w_ready = 1'b0;
  logic [31:0] dmem_w_data;
  logic [3:0]  dmem_w_strb;
  logic        pending_reads_down = 1'b0, pending_writes_down = 1'b0;
  logic [COUNTER_W-1:0] pending_reads, pending_writes;
  logic        response_stall = 1'b0, valid_o;
  logic [31:0] out_address;
  logic        out_write, out_fence, out_is_memory, out_misaligned;
  logic [1:0]  out_size, dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  hsv_core_mem_request #(.COUNTER_W(COUNTER_W)) dut (
    .clk_core(clk_core), .rst_core(rst_core), .flush(flush),
    .valid_i(valid_i), .request_stall(request_stall),
    .in_address(in_address), .in_write(in_write), .in_size(in_size),
    .in_wdata(in_wdata), .in_fence(in_fence), .in_is_memory(in_is_memory),
    .dmem_ar_valid(dmem_ar_valid), .dmem_ar_ready(dmem_ar_ready), .dmem_ar_addr(dmem_ar_addr),
    .dmem_aw_valid(dmem_aw_valid), .dmem_aw_ready(dmem_aw_ready), .dmem_aw_addr(dmem_aw_addr),
    .dmem_w_valid(dmem_w_valid), .dmem_w_ready(dmem_w_ready),
    .dmem_w_data(dmem_w_data), .dmem_w_strb(dmem_w_strb),
    .pending_reads_down(pending_reads_down), .pending_writes_down(pending_writes_down),
    .pending_reads(pending_reads), .pending_writes(pending_writes),
    .response_stall(response_stall), .valid_o(valid_o),
    .out_address(out_address), .out_write(out_write), .out_size(out_size),
    .out_fence(out_fence), .out_is_memory(out_is_memory),
    .out_misaligned(out_misaligned), .state_o(dbg_state)
  );

  // Clock / reset
  always #5 clk_core = ~clk_core;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every op the response stage takes must be the next expected one.
  always @(negedge clk_core) begin
    logic [31:0] e;
    if (!rst_core && valid_o && !response_stall) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      check("fwd_addr", out_address, e);
    end
  end

  // Driver tasks. Timing reference: called and returning at posedge+1.
  task automatic tick();
    @(posedge clk_core); #1;
  endtask

  task automatic drive_op(input logic [31:0] a, input logic w, input logic [1:0] sz,
                          input logic [31:0] d, input logic f, input logic m);
    valid_i = 1'b1; in_address = a; in_write = w; in_size = sz;
    in_wdata = d; in_fence = f; in_is_memory = m;
  endtask

  task automatic wait_accept();
    int n = 0;
    #1;
    while (request_stall && n < 50) begin
      @(posedge clk_core); #2; n++;
    end
    if (request_stall) check("accept_timeout", {31'b0, request_stall}, 32'h0);
    @(posedge clk_core); #1;
    valid_i = 1'b0;
  endtask

  task automatic store_quick(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                             input logic [31:0] exp_bus, input logic [31:0] exp_data,
                             input logic [3:0] exp_strb, input logic [31:0] exp_pw);
    dmem_aw_ready = 1'b1; dmem_w_ready = 1'b1;
    exp_q.push_back(a);
    drive_op(a, 1'b1, sz, d, 1'b0, 1'b1);
    wait_accept();
    #1;
    check("st_aw_valid", {31'b0, dmem_aw_valid}, 32'h1);
    check("st_aw_addr", dmem_aw_addr, exp_bus);
    check("st_w_data", dmem_w_data, exp_data);
    check("st_w_strb", {28'b0, dmem_w_strb}, {28'b0, exp_strb});
    tick();
    check("st_valid_o", {31'b0, valid_o}, 32'h1);
    check("st_pw", {28'b0, pending_writes}, exp_pw);
    dmem_aw_ready = 1'b0; dmem_w_ready = 1'b0;
  endtask

  task automatic load_quick(input logic [31:0] a);
    dmem_ar_ready = 1'b1;
    exp_q.push_back(a);
    drive_op(a, 1'b0, 2'd2, 32'h0, 1'b0, 1'b1);
    wait_accept();
    tick();
    dmem_ar_ready = 1'b0;
  endtask

  task automatic pw_down();
    pending_writes_down = 1'b1; tick(); pending_writes_down = 1'b0;
  endtask

  task automatic pr_down();
    pending_reads_down = 1'b1; tick(); pending_reads_down = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_valid_o", {31'b0, valid_o}, 32'h0);
    check("rst_state", {30'b0, dbg_state}, 32'h0);
    check("rst_pr", {28'b0, pending_reads}, 32'h0);
    check("rst_pw", {28'b0, pending_writes}, 32'h0);
    check("rst_ar_valid", {31'b0, dmem_ar_valid}, 32'h0);
    check("rst_stall", {31'b0, request_stall}, 32'h0);
    @(posedge clk_core); #1; rst_core = 1'b0;
    tick();

    // Store byte 0x1003 / 0xAB
    store_quick(32'h1003, 2'd0, 32'hAB, 32'h1000, 32'hABABABAB, 4'b1000, 32'd1);
    check("sb_out_addr", out_address, 32'h1003);
    pw_down();
    // Store half 0x5002 / 0x1234
    store_quick(32'h5002, 2'd1, 32'h1234, 32'h5000, 32'h12341234, 4'b1100, 32'd1);
    pw_down();
    check("pw_after_down", {28'b0, pending_writes}, 32'h0);

    // Load half 0x2002, AR ready low for 3 cycles
    dmem_ar_ready = 1'b0;
    exp_q.push_back(32'h2002);
    drive_op(32'h2002, 1'b0, 2'd1, 32'h0, 1'b0, 1'b1);
    wait_accept();
    repeat (3) begin
      #1;
      check("lh_ar_valid", {31'b0, dmem_ar_valid}, 32'h1);
      check("lh_ar_addr", dmem_ar_addr, 32'h2000);
      check("lh_stall", {31'b0, request_stall}, 32'h1);
      tick();
    end
    dmem_ar_ready = 1'b1;
    tick();
    dmem_ar_ready = 1'b0;
    check("lh_pr", {28'b0, pending_reads}, 32'h1);
    check("lh_valid_o", {31'b0, valid_o}, 32'h1);
    check("lh_out_size", {30'b0, out_size}, 32'h1);
    check("lh_ar_drop", {31'b0, dmem_ar_valid}, 32'h0);
    pr_down();

    // Misaligned load word 0x3001
    exp_q.push_back(32'h3001);
    drive_op(32'h3001, 1'b0, 2'd2, 32'h0, 1'b0, 1'b1);
    wait_accept();
    check("mis_valid_o", {31'b0, valid_o}, 32'h1);
    check("mis_flag", {31'b0, out_misaligned}, 32'h1);
    check("mis_no_ar", {31'b0, dmem_ar_valid}, 32'h0);
    check("mis_state", {30'b0, dbg_state}, 32'h0);
    tick();
    check("mis_pr", {28'b0, pending_reads}, 32'h0);

    // Fence: forwarded with no bus traffic
    exp_q.push_back(32'h3100);
    drive_op(32'h3100, 1'b0, 2'd2, 32'h0, 1'b1, 1'b1);
    wait_accept();
    check("fence_out", {31'b0, out_fence}, 32'h1);
    check("fence_mis", {31'b0, out_misaligned}, 32'h0);
    check("fence_no_ar", {31'b0, dmem_ar_valid}, 32'h0);
    in_fence = 1'b0;
    tick();

    // Store word with AW done in cycle 1 and W in cycle 3
    exp_q.push_back(32'h4000);
    drive_op(32'h4000, 1'b1, 2'd2, 32'h12345678, 1'b0, 1'b1);
    wait_accept();
    dmem_aw_ready = 1'b1;
    tick();
    dmem_aw_ready = 1'b0;
    check("sw_aw_dropped", {31'b0, dmem_aw_valid}, 32'h0);
    check("sw_w_held", {31'b0, dmem_w_valid}, 32'h1);
    check("sw_pw", {28'b0, pending_writes}, 32'h1);
    check("sw_no_fwd_1", {31'b0, valid_o}, 32'h0);
    tick();
    check("sw_w_held2", {31'b0, dmem_w_valid}, 32'h1);
    check("sw_aw_still_low", {31'b0, dmem_aw_valid}, 32'h0);
    check("sw_w_data", dmem_w_data, 32'h12345678);
    check("sw_w_strb", {28'b0, dmem_w_strb}, 32'hF);
    dmem_w_ready = 1'b1;
    tick();
    dmem_w_ready = 1'b0;
    check("sw_fwd", {31'b0, valid_o}, 32'h1);
    check("sw_out_write", {31'b0, out_write}, 32'h1);
    check("sw_w_dropped", {31'b0, dmem_w_valid}, 32'h0);
    tick();
    check("sw_fwd_once", {31'b0, valid_o}, 32'h0);
    pw_down();

    // Flush during ISSUE of a stalled load
    exp_q.push_back(32'h6000); exp_q.pop_back();  // nothing may be forwarded
    drive_op(32'h6000, 1'b0, 2'd2, 32'h0, 1'b0, 1'b1);
    wait_accept();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_state_drain", {30'b0, dbg_state}, 32'h2);
    check("fl_ar_held", {31'b0, dmem_ar_valid}, 32'h1);
    check("fl_valid_o", {31'b0, valid_o}, 32'h0);
    check("fl_pr0", {28'b0, pending_reads}, 32'h0);
    dmem_ar_ready = 1'b1;
    tick();
    dmem_ar_ready = 1'b0;
    check("fl_pr1", {28'b0, pending_reads}, 32'h1);
    check("fl_idle", {30'b0, dbg_state}, 32'h0);
    check("fl_ar_drop", {31'b0, dmem_ar_valid}, 32'h0);
    tick();
    check("fl_no_fwd", {31'b0, valid_o}, 32'h0);
    pr_down();

    // Output register held under response_stall
    response_stall = 1'b1;
    exp_q.push_back(32'h7000);
    drive_op(32'h7000, 1'b0, 2'd0, 32'h0, 1'b1, 1'b1);
    wait_accept();
    drive_op(32'h7100, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    #1;
    check("rs_stall", {31'b0, request_stall}, 32'h1);
    tick(); tick();
    check("rs_hold_valid", {31'b0, valid_o}, 32'h1);
    check("rs_hold_addr", out_address, 32'h7000);
    valid_i = 1'b0; in_fence = 1'b0;
    response_stall = 1'b0;
    tick();
    check("rs_cleared", {31'b0, valid_o}, 32'h0);

    // Read counter saturation, simultaneous up/down, no underflow
    for (int i = 0; i < 15; i++) load_quick(32'h8000 + 32'(i * 4));
    check("sat_pr15", {28'b0, pending_reads}, 32'hF);
    drive_op(32'h8100, 1'b0, 2'd2, 32'h0, 1'b0, 1'b1);
    #1;
    check("sat_stall", {31'b0, request_stall}, 32'h1);
    valid_i = 1'b0;
    tick();
    pr_down();
    check("sat_pr14", {28'b0, pending_reads}, 32'hE);
    dmem_ar_ready = 1'b1;
    exp_q.push_back(32'h9000);
    drive_op(32'h9000, 1'b0, 2'd2, 32'h0, 1'b0, 1'b1);
    wait_accept();
    pending_reads_down = 1'b1;
    tick();
    pending_reads_down = 1'b0;
    dmem_ar_ready = 1'b0;
    check("updown_pr14", {28'b0, pending_reads}, 32'hE);
    pending_reads_down = 1'b1;
    repeat (15) tick();
    pending_reads_down = 1'b0;
    check("no_underflow", {28'b0, pending_reads}, 32'h0);

    // I/O ordering with two writes outstanding
    store_quick(32'hA100, 2'd2, 32'h1, 32'hA100, 32'h1, 4'hF, 32'd1);
    tick();
    store_quick(32'hA104, 2'd2, 32'h2, 32'hA104, 32'h2, 4'hF, 32'd2);
    tick();
    dmem_ar_ready = 1'b1;
    exp_q.push_back(32'hA000);
    drive_op(32'hA000, 1'b0, 2'd2, 32'h0, 1'b0, 1'b0);
    #1;
`ifdef HSV_MEM_REQ_IO_ORDER_EN
    check("io_stall_a", {31'b0, request_stall}, 32'h1);
    tick(); #1;
    check("io_stall_b", {31'b0, request_stall}, 32'h1);
    pending_writes_down = 1'b1;
    tick(); #1;
    check("io_stall_c", {31'b0, request_stall}, 32'h1);
    tick();
    pending_writes_down = 1'b0;
    check("io_pw0", {28'b0, pending_writes}, 32'h0);
`else
    check("io_no_stall", {31'b0, request_stall}, 32'h0);
`endif
    wait_accept();
    check("io_ar_valid", {31'b0, dmem_ar_valid}, 32'h1);
    tick();
    dmem_ar_ready = 1'b0;
    check("io_pr1", {28'b0, pending_reads}, 32'h1);
    check("io_out_io", {31'b0, out_is_memory}, 32'h0);
    pr_down();
    pending_writes_down = 1'b1; tick(); tick(); pending_writes_down = 1'b0;
    check("io_pw_final", {28'b0, pending_writes}, 32'h0);

    tick(); tick();
    check("exp_q_empty", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
